snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared snoop/broadcast bus between the N per-core caches of the multi-core system. It grants one cache at a time, issues a one-cycle broadcast strobe, and collects snoop acknowledgements from every other cache. It then signals completion, or a timeout if acks are missing, and advances fairness to the next requester.

---
 rtl/snoop_bus_if.sv | 25 ++
 rtl/snoop_bus_arbiter.sv | 101 ++++++++++
 tb/tb_snoop_bus_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_if.sv
// Snoop/broadcast bus bundle between the arbiter and the per-core caches.
// The master side is the arbiter; the slave side is the set of caches.
interface snoop_bus_if #(
  parameter int N    = 3,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req;
  logic [N-1:0]    snoop_ack;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            bcast_valid;
  logic            done;
  logic            timeout_err;
  logic            busy;

  modport master (
    input  req, snoop_ack,
    output grant, grant_id, bcast_valid, done, timeout_err, busy
  );

  modport slave (
    output req, snoop_ack,
    input  grant, grant_id, bcast_valid, done, timeout_err, busy
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared snoop bus: grant, broadcast,
// collect acks from every other cache, then complete (or time out).
module snoop_bus_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 15,
  parameter int ID_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic       clk,
  input  logic       reset,
  snoop_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, BCAST, COLLECT, DONE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] ptr;
  logic [N-1:0]    ack_mask;
  logic [TW-1:0]   tcnt;
  logic            flag;

  logic [ID_W-1:0] sel;
  logic [N-1:0]    sel_onehot;
  logic            found;
  logic [N-1:0]    ack_next;

  assign ack_next = ack_mask | bus.snoop_ack;

  // Scan ptr+1, ptr+2, ... so the last-granted cache has the lowest priority.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % N]) begin
        sel   = ID_W'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
    sel_onehot = N'(1) << sel;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= ID_W'(N - 1);
      ack_mask <= '0;
      tcnt     <= '0;
      flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant    <= sel_onehot;
            grant_id <= sel;
            ack_mask <= sel_onehot;  // granted cache never acks itself
            state    <= BCAST;
          end
        end
        BCAST: begin
          ack_mask <= ack_next;
          tcnt     <= '0;
          state    <= (&ack_next) ? DONE : COLLECT;
        end
        COLLECT: begin
          ack_mask <= ack_next;
          tcnt     <= tcnt + TW'(1);
          if (&ack_next) begin
            state <= DONE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= DONE;
            flag  <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          grant    <= '0;
          grant_id <= '0;
          ptr      <= grant_id;
          ack_mask <= '0;
          flag     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_id    = grant_id;
  assign bus.bcast_valid = (state == BCAST);
  assign bus.done        = (state == DONE);
  assign bus.timeout_err = flag;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a 3-cache instance plus a 1-cache
// instance, with hand-computed expected values.
module tb_snoop_bus_arbiter;

  logic clk;
  logic reset;

  snoop_bus_if #(.N(3)) bus3 ();
  snoop_bus_if #(.N(1)) bus1 ();

  snoop_bus_arbiter #(.N(3), .TIMEOUT(15)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  snoop_bus_arbiter #(.N(1), .TIMEOUT(15)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    int  n;
    bit  held;

    reset          = 1'b1;
    bus3.req       = '0;
    bus3.snoop_ack = '0;
    bus1.req       = '0;
    bus1.snoop_ack = '0;
    tick();
    tick();

    // Reset state
    check("rst_grant", 32'(bus3.grant), 32'h0);
    check("rst_grant_id", 32'(bus3.grant_id), 32'h0);
    check("rst_outs", {28'h0, bus3.bcast_valid, bus3.done, bus3.timeout_err, bus3.busy}, 32'h0);
    reset = 1'b0;
    tick();

    // Single requester: grant, ack from the other two in COLLECT, done
    bus3.req = 3'b001;
    tick();
    check("single_grant", 32'(bus3.grant), 32'h1);
    check("single_bcast", 32'(bus3.bcast_valid), 32'h1);
    check("single_busy", 32'(bus3.busy), 32'h1);
    tick();
    check("single_collect_nodone", {30'h0, bus3.done, bus3.bcast_valid}, 32'h0);
    bus3.snoop_ack = 3'b110;
    tick();
    check("single_done", {30'h0, bus3.done, bus3.timeout_err}, 32'h2);
    check("single_grant_held", 32'(bus3.grant), 32'h1);
    bus3.snoop_ack = 3'b000;
    bus3.req       = 3'b000;
    tick();
    check("single_idle", {28'h0, bus3.grant, bus3.busy}, 32'h0);

    // Round robin from a fresh reset, all acks returned immediately
    pulse_reset();
    bus3.req       = 3'b111;
    bus3.snoop_ack = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_grant%0d", i), 32'(bus3.grant), 32'(rr_exp[i]));
      tick();
      check($sformatf("rr_done%0d", i), 32'(bus3.done), 32'h1);
      tick();
      check($sformatf("rr_idle%0d", i), 32'(bus3.grant), 32'h0);
    end
    bus3.req       = 3'b000;
    bus3.snoop_ack = 3'b000;
    tick();  // ends in IDLE with ptr=0 after the fourth grant (cache 0)

    // Timeout: only cache 0 acks for a grant to cache 1
    bus3.req       = 3'b010;
    bus3.snoop_ack = 3'b001;
    tick();
    check("to_grant", 32'(bus3.grant), 32'h2);
    n    = 0;
    held = 1'b1;
    while (!bus3.done && n < 40) begin
      tick();
      n++;
      if (bus3.grant !== 3'b010) held = 1'b0;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_err", {30'h0, bus3.done, bus3.timeout_err}, 32'h3);
    check("to_grant_held", 32'(held), 32'h1);
    bus3.req       = 3'b000;
    bus3.snoop_ack = 3'b000;
    tick();
    check("to_err_clear", 32'(bus3.timeout_err), 32'h0);

    // Last missing acks land on the final COLLECT cycle
    bus3.req = 3'b100;
    tick();
    check("late_grant", 32'(bus3.grant), 32'h4);
    for (int i = 0; i < 15; i++) tick();
    check("late_not_done", 32'(bus3.done), 32'h0);
    bus3.snoop_ack = 3'b011;
    tick();
    check("late_done", {30'h0, bus3.done, bus3.timeout_err}, 32'h2);
    bus3.req       = 3'b000;
    bus3.snoop_ack = 3'b000;
    tick();

    // Reset mid-transaction, then scan restarts at cache 0
    bus3.req = 3'b100;
    tick();
    tick();
    tick();
    check("abort_pre", {29'h0, bus3.grant}, 32'h4);
    reset = 1'b1;
    #1;
    check("abort_async", {25'h0, bus3.grant, bus3.bcast_valid, bus3.done, bus3.timeout_err, bus3.busy}, 32'h0);
    bus3.req = 3'b101;
    tick();
    check("abort_no_done", 32'(bus3.done), 32'h0);
    reset = 1'b0;
    tick();
    check("abort_regrant", 32'(bus3.grant), 32'h1);
    bus3.snoop_ack = 3'b110;
    tick();
    check("abort_regrant_done", 32'(bus3.done), 32'h1);
    bus3.req       = 3'b000;
    bus3.snoop_ack = 3'b000;
    tick();

    // Single-cache instance: no acks needed
    bus1.req = 1'b1;
    tick();
    check("n1_grant", {30'h0, bus1.grant, bus1.bcast_valid}, 32'h3);
    tick();
    check("n1_done", {30'h0, bus1.done, bus1.timeout_err}, 32'h2);
    bus1.req = 1'b0;
    tick();
    check("n1_idle", {30'h0, bus1.grant, bus1.busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
